// File: rtl/chess_clock_timer_pkg.sv
// Shared types and time-word helpers for the two-player chess clock core.
// A word is {1'b0, minutes[2:0], seconds[5:0]}, bounded to 5:59.
package chess_clock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN_W,
        RUN_B,
        PAUSED,
        DONE
    } state_t;

    localparam int MIN_W   = 3;
    localparam int SEC_W   = 6;
    localparam int WORD_W  = 10;
    localparam int MAX_MIN = 5;
    localparam int MAX_SEC = 59;

    typedef struct packed {
        logic [MIN_W-1:0] min;
        logic [SEC_W-1:0] sec;
    } mmss_t;

    function automatic logic [WORD_W-1:0] pack_word(mmss_t t);
        return {1'b0, t};
    endfunction

    function automatic mmss_t unpack_word(logic [WORD_W-1:0] w);
        return mmss_t'(w[WORD_W-2:0]);
    endfunction

    function automatic logic is_zero(mmss_t t);
        return (t == '0);
    endfunction

    // One-second countdown with minute borrow; 0:00 stays at 0:00.
    function automatic mmss_t dec_time(mmss_t t);
        mmss_t r;
        r = t;
        if (t.sec != '0) begin
            r.sec = t.sec - 1'b1;
        end else if (t.min != '0) begin
            r.min = t.min - 1'b1;
            r.sec = SEC_W'(MAX_SEC);
        end
        return r;
    endfunction

    function automatic mmss_t sat_add(mmss_t t, int inc);
        int    total;
        mmss_t r;
        total = int'(t.min) * (MAX_SEC + 1) + int'(t.sec) + inc;
        if (total > MAX_MIN * (MAX_SEC + 1) + MAX_SEC)
            total = MAX_MIN * (MAX_SEC + 1) + MAX_SEC;
        r.min = MIN_W'(total / (MAX_SEC + 1));
        r.sec = SEC_W'(total % (MAX_SEC + 1));
        return r;
    endfunction

endpackage

// File: rtl/chess_clock_timer_tick_divider.sv
// Prescaler producing a one-cycle tick every CLK_HZ enabled clocks.
// clr restarts the second; the tick of the clearing cycle is still reported.
module tick_divider #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(CLK_HZ > 1 ? CLK_HZ : 2);

    logic [CNT_W-1:0] count;
    logic             at_end;

    assign at_end = (count == CNT_W'(CLK_HZ - 1));
    assign tick   = en && at_end;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= at_end ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/chess_clock_timer.sv
// Two-player countdown core feeding the digit-glyph decoder.
// Optional per-move increment is built when CHESS_CLOCK_INCREMENT_EN is defined.
module chess_clock_timer
    import chess_clock_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int START_MIN = 5,
    parameter int START_SEC = 0,
    parameter int INC_SEC   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       move_w,
    input  logic       move_b,
    input  logic       pause,
    output logic [9:0] countdownW,
    output logic [9:0] countdownB,
    output logic       active_w,
    output logic       active_b,
    output logic       flag_w,
    output logic       flag_b
);

    if ((START_MIN > MAX_MIN) || (START_SEC > MAX_SEC) || (INC_SEC < 0) || (CLK_HZ < 1)) begin : g_bad_cfg
        $error("chess_clock_timer: parameter out of range");
    end

    localparam mmss_t START_T = '{min: MIN_W'(START_MIN), sec: SEC_W'(START_SEC)};

    state_t state;
    logic   saved_b;
    mmss_t  t_w, t_b;

    logic   running, count_en, tick, move_ok, flag_fall;
    mmss_t  cur, cur_ticked, cur_next;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        running    = (state == RUN_W) || (state == RUN_B);
        count_en   = running && !start && !pause;
        cur        = (state == RUN_B) ? t_b : t_w;
        cur_ticked = tick ? dec_time(cur) : cur;
        flag_fall  = tick && is_zero(cur_ticked);
        move_ok    = count_en && (((state == RUN_W) && move_w) || ((state == RUN_B) && move_b));
        cur_next   = cur_ticked;
`ifdef CHESS_CLOCK_INCREMENT_EN
        if (move_ok && !flag_fall)
            cur_next = sat_add(cur_ticked, INC_SEC);
`endif
    end

    tick_divider #(.CLK_HZ(CLK_HZ)) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .en    (count_en),
        .clr   (start || move_ok),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            saved_b  <= 1'b0;
            t_w      <= START_T;
            t_b      <= START_T;
            active_w <= 1'b0;
            active_b <= 1'b0;
            flag_w   <= 1'b0;
            flag_b   <= 1'b0;
        end else if (start) begin
            state    <= RUN_W;
            t_w      <= START_T;
            t_b      <= START_T;
            active_w <= 1'b1;
            active_b <= 1'b0;
            flag_w   <= 1'b0;
            flag_b   <= 1'b0;
        end else begin
            case (state)
                RUN_W, RUN_B: begin
                    if (pause) begin
                        state    <= PAUSED;
                        saved_b  <= (state == RUN_B);
                        active_w <= 1'b0;
                        active_b <= 1'b0;
                    end else begin
                        if (state == RUN_W) t_w <= cur_next;
                        else                t_b <= cur_next;
                        // Flag fall outranks a same-cycle move: the game is over.
                        if (flag_fall) begin
                            state    <= DONE;
                            active_w <= 1'b0;
                            active_b <= 1'b0;
                            if (state == RUN_W) flag_w <= 1'b1;
                            else                flag_b <= 1'b1;
                        end else if (move_ok) begin
                            state    <= (state == RUN_W) ? RUN_B : RUN_W;
                            active_w <= (state == RUN_B);
                            active_b <= (state == RUN_W);
                        end
                    end
                end
                PAUSED: begin
                    if (pause) begin
                        state    <= saved_b ? RUN_B : RUN_W;
                        active_w <= !saved_b;
                        active_b <= saved_b;
                    end
                end
                default: ;
            endcase
        end
    end

    assign countdownW = pack_word(t_w);
    assign countdownB = pack_word(t_b);

endmodule

// File: tb/tb_chess_clock_timer.sv
// Self-checking bench: three instances (0:03, 1:00, 5:00 starts) share stimulus and
// are compared each cycle against a seconds-based model, plus literal spot checks.
module tb_chess_clock_timer;

    localparam int CLK_HZ  = 10;
    localparam int INC_SEC = 2;
    localparam int MAX_T   = 5 * 60 + 59;
    localparam int START_S [3] = '{3, 60, 300};

    logic clk = 1'b0;
    logic reset, start, move_w, move_b, pause;
    logic [9:0] cw [3];
    logic [9:0] cb [3];
    logic aw [3], ab [3], fw [3], fb [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    chess_clock_timer #(.CLK_HZ(CLK_HZ), .START_MIN(0), .START_SEC(3), .INC_SEC(INC_SEC)) dut_a (
        .clk(clk), .reset(reset), .start(start), .move_w(move_w), .move_b(move_b), .pause(pause),
        .countdownW(cw[0]), .countdownB(cb[0]), .active_w(aw[0]), .active_b(ab[0]),
        .flag_w(fw[0]), .flag_b(fb[0]));

    chess_clock_timer #(.CLK_HZ(CLK_HZ), .START_MIN(1), .START_SEC(0), .INC_SEC(INC_SEC)) dut_b (
        .clk(clk), .reset(reset), .start(start), .move_w(move_w), .move_b(move_b), .pause(pause),
        .countdownW(cw[1]), .countdownB(cb[1]), .active_w(aw[1]), .active_b(ab[1]),
        .flag_w(fw[1]), .flag_b(fb[1]));

    chess_clock_timer #(.CLK_HZ(CLK_HZ), .START_MIN(5), .START_SEC(0), .INC_SEC(INC_SEC)) dut_c (
        .clk(clk), .reset(reset), .start(start), .move_w(move_w), .move_b(move_b), .pause(pause),
        .countdownW(cw[2]), .countdownB(cb[2]), .active_w(aw[2]), .active_b(ab[2]),
        .flag_w(fw[2]), .flag_b(fb[2]));

    // Model: remaining time in plain seconds; side 0 = nobody running, 1 = White, 2 = Black.
    typedef struct {
        int tw;
        int tb;
        bit fw;
        bit fb;
        int side;
        bit paused;
        int saved;
        int cnt;
    } model_t;

    model_t m [3];

    function automatic model_t model_init(int st);
        model_t s;
        s.tw = st; s.tb = st; s.fw = 0; s.fb = 0;
        s.side = 0; s.paused = 0; s.saved = 1; s.cnt = 0;
        return s;
    endfunction

    function automatic model_t model_step(model_t s_in, int st, bit go, bit ps, bit mw, bit mb);
        model_t s;
        bit     tick, mover;
        int     t;
        s = s_in;
        if (go) begin
            s = model_init(st);
            s.side = 1;
            return s;
        end
        if (s.paused) begin
            if (ps) begin
                s.paused = 0;
                s.side   = s.saved;
            end
            return s;
        end
        if (s.side == 0) return s;
        if (ps) begin
            s.saved  = s.side;
            s.side   = 0;
            s.paused = 1;
            return s;
        end
        mover = (s.side == 1 && mw) || (s.side == 2 && mb);
        tick  = (s.cnt == CLK_HZ - 1);
        s.cnt = (tick || mover) ? 0 : s.cnt + 1;
        t = (s.side == 1) ? s.tw : s.tb;
        if (tick) t = (t > 0) ? t - 1 : 0;
        if (tick && t == 0) begin
            if (s.side == 1) begin s.tw = 0; s.fw = 1; end
            else             begin s.tb = 0; s.fb = 1; end
            s.side = 0;
            return s;
        end
`ifdef CHESS_CLOCK_INCREMENT_EN
        if (mover) t = (t + INC_SEC > MAX_T) ? MAX_T : t + INC_SEC;
`endif
        if (s.side == 1) s.tw = t;
        else             s.tb = t;
        if (mover) s.side = (s.side == 1) ? 2 : 1;
        return s;
    endfunction

    function automatic logic [9:0] to_word(int secs);
        return {1'b0, 3'(secs / 60), 6'(secs % 60)};
    endfunction

    function automatic logic [23:0] model_vec(model_t s);
        return {to_word(s.tw), to_word(s.tb), s.side == 1, s.side == 2, s.fw, s.fb};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) m[i] <= model_init(START_S[i]);
            else       m[i] <= model_step(m[i], START_S[i], start, pause, move_w, move_b);
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++)
            check($sformatf("model_dut%0d", i),
                  {8'h0, cw[i], cb[i], aw[i], ab[i], fw[i], fb[i]}, {8'h0, model_vec(m[i])});
    end

    // Entered and left at 2 time units after a rising edge; the pulse is taken by the next edge.
    task automatic drive(input bit go, input bit ps, input bit mw, input bit mb);
        start = go; pause = ps; move_w = mw; move_b = mb;
        @(posedge clk); #2;
        start = 0; pause = 0; move_w = 0; move_b = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    initial begin
        start = 0; pause = 0; move_w = 0; move_b = 0;
        reset = 0;
        #1 reset = 1;
        repeat (3) @(posedge clk);
        #2 reset = 0;

        check("rst_cw_a", cw[0], 10'h003);
        check("rst_cb_b", cb[1], 10'h040);
        check("rst_cw_c", cw[2], 10'h140);
        check("rst_act", {aw[2], ab[2], fw[2], fb[2]}, 4'b0000);

        drive(0, 1, 1, 0);
        check("idle_ignores", {aw[2], ab[2]}, 2'b00);

        // Countdown to flag fall on the 0:03 instance; borrow on the others.
        drive(1, 0, 0, 0);
        check("start_aw", aw[0], 1'b1);
        idle(10);
        check("t1_a_2s", cw[0], 10'h002);
        check("t2_borrow_b", cw[1], 10'h03B);
        check("t2_borrow_c", cw[2], 10'h13B);
        idle(20);
        check("t1_flag_cw", cw[0], 10'h000);
        check("t1_flag_w", {fw[0], aw[0], ab[0]}, 3'b100);
        check("t1_cb_hold", cb[0], 10'h003);
        check("t1_b_57", cw[1], 10'h039);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle(10);
        check("t1_done_hold", {cw[0], fw[0]}, {10'h000, 1'b1});

        // Move clears the prescaler: Black's first tick is a full second later.
        drive(1, 0, 0, 0);
        idle(5);
        drive(0, 0, 1, 0);
        check("t3_turn", {aw[2], ab[2]}, 2'b01);
        idle(9);
        check("t3_no_tick", cb[2], 10'h140);
        idle(1);
        check("t3_tick", {cw[2], cb[2]}, {10'h140, 10'h13B});

        // Tick and move on the same edge: decrement lands on the mover.
        drive(1, 0, 0, 0);
        idle(9);
        drive(0, 0, 1, 0);
        check("tick_move_c", {cw[2], ab[2]}, {10'h13B, 1'b1});

        drive(1, 0, 0, 0);
        idle(2);
        drive(0, 0, 0, 1);
        check("t5_mb_ignored", {aw[2], ab[2]}, 2'b10);

        // Pause holds the prescaler; resume ticks after the remaining six cycles.
        drive(1, 0, 0, 0);
        idle(4);
        drive(0, 1, 0, 0);
        check("t4_paused", {aw[2], ab[2]}, 2'b00);
        idle(50);
        check("t4_frozen", cw[2], 10'h140);
        drive(0, 0, 1, 0);
        check("t5_mw_paused", {aw[2], ab[2]}, 2'b00);
        drive(0, 1, 0, 0);
        check("t4_resume", aw[2], 1'b1);
        idle(5);
        check("t4_before", cw[2], 10'h140);
        idle(1);
        check("t4_tick", cw[2], 10'h13B);

        drive(0, 0, 1, 0);
        check("t5_to_b", ab[2], 1'b1);
        drive(1, 0, 1, 0);
        check("t5_start_wins", {aw[2], ab[2], cw[2], cb[2]}, {2'b10, 10'h140, 10'h140});
        drive(0, 1, 1, 0);
        check("pause_over_move", {aw[2], ab[2]}, 2'b00);
        drive(0, 1, 0, 0);
        check("resume_w", aw[2], 1'b1);

        // Black flag fall on the 0:03 instance.
        drive(1, 0, 0, 0);
        drive(0, 0, 1, 0);
        idle(30);
        check("flag_b", {fb[0], fw[0], cb[0], ab[0]}, {2'b10, 10'h000, 1'b0});

        // Asynchronous reset mid-run.
        reset = 1;
        #1;
        check("async_rst", {cb[2], ab[2], fb[0]}, {10'h140, 2'b00});
        @(posedge clk); #2;
        reset = 0;
        idle(2);

`ifdef CHESS_CLOCK_INCREMENT_EN
        drive(1, 0, 0, 0);
        idle(10);
        drive(0, 0, 1, 0);
        check("inc_carry", cw[1], 10'h041);
        drive(1, 0, 0, 0);
        for (int k = 0; k < 29; k++) begin
            drive(0, 0, 1, 0);
            drive(0, 0, 0, 1);
        end
        check("inc_558", cw[2], 10'h17A);
        drive(0, 0, 1, 0);
        check("inc_sat", cw[2], 10'h17B);
`endif

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
